// File: rtl/irq_ctrl.sv
// Interrupt controller: up to 8 sources with enable/pending/mode/polarity on a 5-bit CSR bus.
// Sources pass through a 2-flop synchroniser (1 flop when SYNC_IN=0); irq_out is registered.
module irq_ctrl #(
    parameter logic [4:0] BASE_ADDR = 5'h18,
    parameter int         NUM_IRQS  = 8,
    parameter bit         SYNC_IN   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          csr_a,
    input  logic [7:0]          csr_di,
    input  logic                csr_we,
    output logic [7:0]          csr_do,
    input  logic [NUM_IRQS-1:0] irq_in,
    output logic                irq_out
);
    localparam logic [7:0] VALID_MASK = 8'((9'd1 << NUM_IRQS) - 9'd1);
    localparam logic [4:0] OFF_ENABLE = 5'd0;
    localparam logic [4:0] OFF_PEND   = 5'd1;
    localparam logic [4:0] OFF_MODE   = 5'd2;
    localparam logic [4:0] OFF_POL    = 5'd3;
    localparam logic [4:0] OFF_RAW    = 5'd4;

    logic [4:0] off;
    logic       hit;
    logic       wr;
    logic [7:0] irq_ext;
    logic [7:0] w1c;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] lvl_set;
    logic [7:0] edge_set;
    logic [7:0] set;

    logic [7:0] en_d, en_q;
    logic [7:0] pend_d, pend_q;
    logic [7:0] mode_d, mode_q;
    logic [7:0] pol_d, pol_q;
    logic [7:0] s0_d, s0_q;
    logic [7:0] s1_d, s1_q;
    logic [7:0] prev_d, prev_q;
    logic       irq_out_d, irq_out_q;

    always_comb begin
        irq_ext = '0;
        irq_ext[NUM_IRQS-1:0] = irq_in;

        off = csr_a - BASE_ADDR;
        hit = (csr_a >= BASE_ADDR) && (off <= OFF_RAW);
        wr  = csr_we && hit;

        s0_d   = irq_ext;
        s1_d   = SYNC_IN ? s0_q : irq_ext;
        prev_d = s1_q;

        en_d   = (wr && off == OFF_ENABLE) ? (csr_di & VALID_MASK) : en_q;
        mode_d = (wr && off == OFF_MODE)   ? (csr_di & VALID_MASK) : mode_q;
        pol_d  = (wr && off == OFF_POL)    ? (csr_di & VALID_MASK) : pol_q;
        w1c    = (wr && off == OFF_PEND)   ? (csr_di & VALID_MASK) : 8'h00;

        // Polarity is applied after edge detection, so rewriting POL/MODE never fakes an edge.
        rise     = s1_q & ~prev_q;
        fall     = ~s1_q & prev_q;
        lvl_set  = s1_q ^ pol_q;
        edge_set = (pol_q & fall) | (~pol_q & rise);
        set      = ((~mode_q & lvl_set) | (mode_q & edge_set)) & VALID_MASK;

        pend_d    = ((pend_q & ~w1c) | set) & VALID_MASK;
        irq_out_d = |(pend_q & en_q & VALID_MASK);

        csr_do = 8'h00;
        if (hit) begin
            case (off)
                OFF_ENABLE: csr_do = en_q;
                OFF_PEND:   csr_do = pend_q;
                OFF_MODE:   csr_do = mode_q;
                OFF_POL:    csr_do = pol_q;
                OFF_RAW:    csr_do = s1_q & VALID_MASK;
                default:    csr_do = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= '0;
            pend_q    <= '0;
            mode_q    <= '0;
            pol_q     <= '0;
            s0_q      <= '0;
            s1_q      <= '0;
            prev_q    <= '0;
            irq_out_q <= 1'b0;
        end else begin
            en_q      <= en_d;
            pend_q    <= pend_d;
            mode_q    <= mode_d;
            pol_q     <= pol_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            prev_q    <= prev_d;
            irq_out_q <= irq_out_d;
        end
    end

    assign irq_out = irq_out_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: 8-source instance plus a 4-source instance sharing the CSR bus.
module tb_irq_ctrl;
    localparam logic [4:0] BASE = 5'h18;
    localparam logic [4:0] A_EN   = BASE + 5'd0;
    localparam logic [4:0] A_PEND = BASE + 5'd1;
    localparam logic [4:0] A_MODE = BASE + 5'd2;
    localparam logic [4:0] A_POL  = BASE + 5'd3;
    localparam logic [4:0] A_RAW  = BASE + 5'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] csr_a;
    logic [7:0] csr_di;
    logic       csr_we;
    logic [7:0] csr_do;
    logic [7:0] irq_in;
    logic       irq_out;
    logic [7:0] csr_do4;
    logic [3:0] irq_in4;
    logic       irq_out4;

    int total = 0;
    int bad   = 0;

    irq_ctrl #(.BASE_ADDR(BASE), .NUM_IRQS(8), .SYNC_IN(1'b1)) dut (
        .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
        .csr_do(csr_do), .irq_in(irq_in), .irq_out(irq_out)
    );

    irq_ctrl #(.BASE_ADDR(BASE), .NUM_IRQS(4), .SYNC_IN(1'b1)) dut4 (
        .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
        .csr_do(csr_do4), .irq_in(irq_in4), .irq_out(irq_out4)
    );

    always #10 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic csr_write(input logic [4:0] a, input logic [7:0] d);
        csr_a  = a;
        csr_di = d;
        csr_we = 1'b1;
        step(1);
        csr_we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [7:0] exp);
        csr_a = a;
        #1;
        check(tag, csr_do, exp);
    endtask

    task automatic rd4(input string tag, input logic [4:0] a, input logic [7:0] exp);
        csr_a = a;
        #1;
        check(tag, csr_do4, exp);
    endtask

    initial begin
        rst = 1'b1; csr_a = 5'd0; csr_di = 8'h00; csr_we = 1'b0;
        irq_in = 8'hFF; irq_in4 = 4'hA;

        // 1: reset, RAW follows the input two clocks after release
        step(2);
        check("rst_irq_out", {7'd0, irq_out}, 8'h00);
        rd("rst_en", A_EN, 8'h00);
        rd("rst_pend", A_PEND, 8'h00);
        rd("rst_mode", A_MODE, 8'h00);
        rd("rst_pol", A_POL, 8'h00);
        rd("rst_raw", A_RAW, 8'h00);
        rst = 1'b0;
        step(2);
        rd("raw_ff", A_RAW, 8'hFF);
        rd("pend_still0", A_PEND, 8'h00);
        check("irq_out_post_rst", {7'd0, irq_out}, 8'h00);
        irq_in = 8'h00; rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(2);

        // 2: level source 0
        csr_write(A_EN, 8'h01);
        irq_in = 8'h01;
        step(2);
        rd("lvl_pend_e2", A_PEND, 8'h00);
        step(1);
        rd("lvl_pend_e3", A_PEND, 8'h01);
        check("lvl_irq_e3", {7'd0, irq_out}, 8'h00);
        step(1);
        check("lvl_irq_e4", {7'd0, irq_out}, 8'h01);
        csr_write(A_PEND, 8'h01);
        rd("lvl_w1c_active", A_PEND, 8'h01);
        irq_in = 8'h00;
        step(2);
        csr_write(A_PEND, 8'h01);
        rd("lvl_w1c_clear", A_PEND, 8'h00);
        check("lvl_irq_lag", {7'd0, irq_out}, 8'h01);
        step(1);
        check("lvl_irq_drop", {7'd0, irq_out}, 8'h00);

        // 3: falling edge on source 2
        csr_write(A_MODE, 8'h04);
        csr_write(A_POL, 8'h04);
        csr_write(A_EN, 8'h04);
        irq_in = 8'h04;
        step(3);
        rd("fall_rise_ignored", A_PEND, 8'h00);
        irq_in = 8'h00;
        step(3);
        rd("fall_pend", A_PEND, 8'h04);
        step(1);
        check("fall_irq", {7'd0, irq_out}, 8'h01);
        csr_write(A_PEND, 8'h04);
        rd("fall_w1c", A_PEND, 8'h00);
        step(3);
        rd("fall_stays0", A_PEND, 8'h00);
        check("fall_irq_off", {7'd0, irq_out}, 8'h00);

        // 4: rising edge on source 3 coinciding with W1C of that bit
        csr_write(A_MODE, 8'h0C);
        irq_in = 8'h08;
        step(2);
        csr_write(A_PEND, 8'h08);
        rd("collide_set_wins", A_PEND, 8'h08);
        step(1);
        rd("collide_hold", A_PEND, 8'h08);
        csr_write(A_PEND, 8'h08);
        rd("collide_then_clear", A_PEND, 8'h00);

        // 5: polarity toggles on a static input, then enable gating
        csr_write(A_POL, 8'h0C);
        csr_write(A_POL, 8'h04);
        step(2);
        rd("pol_toggle_no_set", A_PEND, 8'h00);
        csr_write(A_EN, 8'h08);
        irq_in = 8'h00;
        step(3);
        rd("fall_on_rise_bit", A_PEND, 8'h00);
        irq_in = 8'h08;
        step(3);
        rd("rise_pend", A_PEND, 8'h08);
        step(1);
        check("rise_irq", {7'd0, irq_out}, 8'h01);
        csr_write(A_EN, 8'h00);
        step(1);
        check("dis_irq", {7'd0, irq_out}, 8'h00);
        rd("dis_pend_kept", A_PEND, 8'h08);
        csr_write(A_EN, 8'h08);
        check("reen_irq_lag", {7'd0, irq_out}, 8'h00);
        step(1);
        check("reen_irq", {7'd0, irq_out}, 8'h01);

        // 6: register width limited to NUM_IRQS; out-of-block reads return 0
        csr_write(A_EN, 8'hFF);
        csr_write(A_MODE, 8'hFF);
        csr_write(A_POL, 8'hFF);
        rd4("n4_en", A_EN, 8'h0F);
        rd4("n4_mode", A_MODE, 8'h0F);
        rd4("n4_pol", A_POL, 8'h0F);
        rd4("n4_raw", A_RAW, 8'h0A);
        rd("n8_en", A_EN, 8'hFF);
        rd("oob_hi8", BASE + 5'd5, 8'h00);
        rd4("oob_hi4", BASE + 5'd5, 8'h00);
        rd("oob_lo8", BASE - 5'd1, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
